// File: rtl/m72_int_sched.sv
// m72_int_sched: M72 interrupt scheduler (event pending, PIC/CPU INTA handshake); optional raster IRQ via M72_RASTER_IRQ_EN
//   clk/reset(async, active-high)/ce; vblank, hblank, v_count, ext_irq: event sources
//   rl_cs/rl_wr/rl_a0/rl_din: raster-line register write port
//   pic_intp/pic_int_req/pic_int_vector/pic_int_ack: PIC side; cpu_intr/cpu_inta/cpu_vector/cpu_vector_valid: CPU side
module m72_int_sched #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       vblank,
  input  logic       hblank,
  input  logic [8:0] v_count,
  input  logic [5:0] ext_irq,
  input  logic       rl_cs,
  input  logic       rl_wr,
  input  logic       rl_a0,
  input  logic [7:0] rl_din,
  output logic [7:0] pic_intp,
  input  logic       pic_int_req,
  input  logic [8:0] pic_int_vector,
  output logic       pic_int_ack,
  output logic       cpu_intr,
  input  logic       cpu_inta,
  output logic [7:0] cpu_vector,
  output logic       cpu_vector_valid
);
  localparam int CW = $clog2(ACK_TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, REQ, ACK1, ACK2, DROP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] pend_q, pend_d, vec_q, vec_d, clr;
  logic vb_q, ack_q, ack_d, valid_q, valid_d, raster_hit;
  logic unused_vec_lsbs;
  assign unused_vec_lsbs = ^pic_int_vector[1:0];
`ifdef M72_RASTER_IRQ_EN
  logic [8:0] rl_q;
  logic hb_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rl_q <= '0;
      hb_q <= 1'b0;
    end else if (ce) begin
      hb_q <= hblank;
      if (rl_cs && rl_wr && rl_a0) rl_q[8] <= rl_din[0];
      if (rl_cs && rl_wr && !rl_a0) rl_q[7:0] <= rl_din;
    end
  end
  assign raster_hit = hblank & ~hb_q & (v_count == rl_q);
`else
  logic unused_raster;
  assign unused_raster = ^{hblank, v_count, rl_cs, rl_wr, rl_a0, rl_din};
  assign raster_hit = 1'b0;
`endif
  // the ack-clear is applied before the OR so a same-cycle set wins
  assign clr = (state_q == ACK2) ? 8'(1) << pic_int_vector[4:2] : '0;
  assign pend_d = (pend_q & ~clr) | {ext_irq, raster_hit, vblank & ~vb_q};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ack_d = 1'b0;
    valid_d = valid_q;
    vec_d = vec_q;
    case (state_q)
      IDLE: state_d = pic_int_req ? REQ : IDLE;
      REQ: begin
        if (cpu_inta) begin
          state_d = ACK1;
          cnt_d = CW'(ACK_TIMEOUT);
        end else if (!pic_int_req) state_d = IDLE;
      end
      // outputs for ACK2 are registered here so they appear one ce after the second strobe
      ACK1: begin
        if (cpu_inta) begin
          state_d = ACK2;
          ack_d = 1'b1;
          valid_d = 1'b1;
          vec_d = {1'b0, pic_int_vector[8:2]};
        end else if (cnt_q == '0) state_d = REQ;
        else cnt_d = cnt_q - CW'(1);
      end
      ACK2: state_d = DROP;
      DROP: begin
        if (!pic_int_req) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      vec_q <= '0;
      vb_q <= 1'b0;
      ack_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      vec_q <= vec_d;
      vb_q <= vblank;
      ack_q <= ack_d;
      valid_q <= valid_d;
    end
  end
  assign pic_intp = pend_q;
  assign pic_int_ack = ack_q;
  assign cpu_intr = (state_q == REQ);
  assign cpu_vector = vec_q;
  assign cpu_vector_valid = valid_q;
endmodule
